// File: rtl/ray_column_rasterizer.sv
// ray_column_rasterizer
// Turns one DDA ray-column beat into SCREEN_H frame-buffer writes (one per
// screen row). Each write is ceiling, wall or floor. The write port is
// valid/ready backpressured. With NUM_BUF=2, writes go to the back buffer and
// the buffers swap at frame end. Beats whose column is out of range are dropped.
//
// Ports:
//   pixel_clk_in    sole clock
//   rst_in          asynchronous active-low reset
//   dda_tvalid_in   column beat valid
//   dda_tready_out  beat accepted when high together with valid
//   dda_tdata_in    {column, line_height, wall_type, side}, side at bit 0
//   dda_tlast_in    last column of the frame
//   wr_valid_out    frame-buffer write valid
//   wr_ready_in     frame buffer accepts write
//   wr_addr_out     buf*W*H + row*W + column
//   wr_data_out     pixel word
//   wr_last_out     final write of the frame
//   frame_done_out  one-cycle pulse after a frame's final write
//   front_buf_out   most recently completed buffer
//   col_err_out     one-cycle pulse when a beat is dropped
module ray_column_rasterizer #(
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 180,
  parameter int COL_W    = 9,
  parameter int LH_W     = 10,
  parameter int TYPE_W   = 3,
  parameter int PIX_W    = 16,
  parameter int NUM_BUF  = 2,
  parameter logic [PIX_W-1:0] CEIL_PIX  = 16'h18C3,
  parameter logic [PIX_W-1:0] FLOOR_PIX = 16'h4208,
  localparam int TDATA_W = COL_W + LH_W + TYPE_W + 1,
  localparam int ADDR_W  = $clog2(NUM_BUF * SCREEN_W * SCREEN_H)
) (
  input  logic               pixel_clk_in,
  input  logic               rst_in,
  input  logic               dda_tvalid_in,
  output logic               dda_tready_out,
  input  logic [TDATA_W-1:0] dda_tdata_in,
  input  logic               dda_tlast_in,
  output logic               wr_valid_out,
  input  logic               wr_ready_in,
  output logic [ADDR_W-1:0]  wr_addr_out,
  output logic [PIX_W-1:0]   wr_data_out,
  output logic               wr_last_out,
  output logic               frame_done_out,
  output logic               front_buf_out,
  output logic               col_err_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_EMIT  = 2'd2;

  localparam int ROW_W = $clog2(SCREEN_H + 1);
  localparam int EXT_W = ((LH_W > ROW_W) ? LH_W : ROW_W) + 1;
  localparam logic [ROW_W-1:0]  H_ROWS     = ROW_W'(SCREEN_H);
  localparam logic [ROW_W-1:0]  ROW_MAX    = ROW_W'(SCREEN_H - 1);
  localparam logic [COL_W:0]    COL_LIM    = (COL_W + 1)'(SCREEN_W);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W);
  localparam logic [ADDR_W-1:0] BUF_SIZE   = ADDR_W'(SCREEN_W * SCREEN_H);

  // Clamp the line height to the screen height.
  function automatic logic [ROW_W-1:0] sat_lh(input logic [LH_W-1:0] lh);
    logic [EXT_W-1:0] ext;
    ext = EXT_W'(lh);
    if (ext > EXT_W'(SCREEN_H)) sat_lh = H_ROWS;
    else                        sat_lh = ROW_W'(lh);
  endfunction

  // Pixel for one row. 'wall' guards the lh=0 case, where the last wall row
  // would otherwise sit one below start.
  function automatic logic [PIX_W-1:0] pix_for(
    input logic [ROW_W-1:0]  row,
    input logic [ROW_W-1:0]  start,
    input logic [ROW_W-1:0]  last_row,
    input logic              wall,
    input logic              sd,
    input logic [TYPE_W-1:0] ty
  );
    logic [PIX_W-1:0] p;
    p              = '0;
    p[PIX_W-1]     = 1'b1;
    p[TYPE_W]      = sd;
    p[TYPE_W-1:0]  = ty;
    if (row < start)                pix_for = CEIL_PIX;
    else if (wall && row <= last_row) pix_for = p;
    else                            pix_for = FLOOR_PIX;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [LH_W-1:0]   lh_q, lh_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic              side_q, side_d;
  logic              last_q, last_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ROW_W-1:0]  start_q, start_d;
  logic [ROW_W-1:0]  lrow_q, lrow_d;
  logic              wall_q, wall_d;
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic              wr_last_q, wr_last_d;
  logic              frame_done_q, frame_done_d;
  logic              front_q, front_d;
  logic              back_q, back_d;
  logic              col_err_q, col_err_d;

  logic [COL_W-1:0]  beat_col;
  logic [ROW_W-1:0]  lh_c, start_c, lrow_c, row_nxt;
  logic              frame_end;

  assign beat_col = dda_tdata_in[TDATA_W-1 -: COL_W];
  assign lh_c     = sat_lh(lh_q);
  assign start_c  = (H_ROWS - lh_c) >> 1;
  assign lrow_c   = start_c + lh_c - ROW_W'(1);
  assign row_nxt  = row_q + ROW_W'(1);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    lh_d         = lh_q;
    type_d       = type_q;
    side_d       = side_q;
    last_d       = last_q;
    row_d        = row_q;
    start_d      = start_q;
    lrow_d       = lrow_q;
    wall_d       = wall_q;
    wr_valid_d   = wr_valid_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_last_d    = wr_last_q;
    front_d      = front_q;
    back_d       = back_q;
    frame_done_d = 1'b0;
    col_err_d    = 1'b0;
    frame_end    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (dda_tvalid_in) begin
          if ({1'b0, beat_col} >= COL_LIM) begin
            // Dropped beat still closes the frame if it carries tlast.
            col_err_d = 1'b1;
            frame_end = dda_tlast_in;
          end else begin
            col_d   = beat_col;
            lh_d    = dda_tdata_in[TYPE_W+LH_W -: LH_W];
            type_d  = dda_tdata_in[TYPE_W:1];
            side_d  = dda_tdata_in[0];
            last_d  = dda_tlast_in;
            state_d = S_SETUP;
          end
        end
      end
      // ---- setup: wall span and row-0 write ----
      S_SETUP: begin
        start_d    = start_c;
        lrow_d     = lrow_c;
        wall_d     = (lh_c != '0);
        row_d      = '0;
        wr_addr_d  = (back_q ? BUF_SIZE : '0) + ADDR_W'(col_q);
        wr_data_d  = pix_for('0, start_c, lrow_c, (lh_c != '0), side_q, type_q);
        wr_last_d  = last_q && (ROW_MAX == '0);
        wr_valid_d = 1'b1;
        state_d    = S_EMIT;
      end
      // ---- emit: one write per row, advanced only on handshake ----
      S_EMIT: begin
        if (wr_ready_in) begin
          if (row_q == ROW_MAX) begin
            wr_valid_d = 1'b0;
            wr_last_d  = 1'b0;
            frame_end  = last_q;
            state_d    = S_IDLE;
          end else begin
            row_d     = row_nxt;
            wr_addr_d = wr_addr_q + ROW_STRIDE;
            wr_data_d = pix_for(row_nxt, start_q, lrow_q, wall_q, side_q, type_q);
            wr_last_d = last_q && (row_nxt == ROW_MAX);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_end) begin
      frame_done_d = 1'b1;
      front_d      = back_q;
      if (NUM_BUF == 2) back_d = ~back_q;
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      lh_q         <= '0;
      type_q       <= '0;
      side_q       <= 1'b0;
      last_q       <= 1'b0;
      row_q        <= '0;
      start_q      <= '0;
      lrow_q       <= '0;
      wall_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_last_q    <= 1'b0;
      frame_done_q <= 1'b0;
      front_q      <= 1'b0;
      back_q       <= 1'b0;
      col_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      lh_q         <= lh_d;
      type_q       <= type_d;
      side_q       <= side_d;
      last_q       <= last_d;
      row_q        <= row_d;
      start_q      <= start_d;
      lrow_q       <= lrow_d;
      wall_q       <= wall_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_last_q    <= wr_last_d;
      frame_done_q <= frame_done_d;
      front_q      <= front_d;
      back_q       <= back_d;
      col_err_q    <= col_err_d;
    end
  end

  assign dda_tready_out = (state_q == S_IDLE);
  assign wr_valid_out   = wr_valid_q;
  assign wr_addr_out    = wr_addr_q;
  assign wr_data_out    = wr_data_q;
  assign wr_last_out    = wr_last_q;
  assign frame_done_out = frame_done_q;
  assign front_buf_out  = front_q;
  assign col_err_out    = col_err_q;

endmodule

// File: tb/tb_ray_column_rasterizer.sv
// Directed bench for ray_column_rasterizer on an 8x6 double-buffered screen.
module tb_ray_column_rasterizer;
  localparam int W       = 8;
  localparam int H       = 6;
  localparam int COL_W   = 9;
  localparam int LH_W    = 10;
  localparam int TYPE_W  = 3;
  localparam int PIX_W   = 16;
  localparam int TDATA_W = COL_W + LH_W + TYPE_W + 1;
  localparam int ADDR_W  = 7;
  localparam logic [15:0] CEIL  = 16'h18C3;
  localparam logic [15:0] FLOOR = 16'h4208;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               tvalid, tready, tlast;
  logic [TDATA_W-1:0] tdata;
  logic               wr_valid, wr_ready, wr_last;
  logic [ADDR_W-1:0]  wr_addr;
  logic [PIX_W-1:0]   wr_data;
  logic               frame_done, front_buf, col_err;

  int checks = 0;
  int errors = 0;
  logic [3:0] pat = 4'b1001;

  always #5 clk = ~clk;

  ray_column_rasterizer #(
    .SCREEN_W(W), .SCREEN_H(H), .COL_W(COL_W), .LH_W(LH_W), .TYPE_W(TYPE_W),
    .PIX_W(PIX_W), .NUM_BUF(2), .CEIL_PIX(CEIL), .FLOOR_PIX(FLOOR)
  ) dut (
    .pixel_clk_in  (clk),
    .rst_in        (rst_n),
    .dda_tvalid_in (tvalid),
    .dda_tready_out(tready),
    .dda_tdata_in  (tdata),
    .dda_tlast_in  (tlast),
    .wr_valid_out  (wr_valid),
    .wr_ready_in   (wr_ready),
    .wr_addr_out   (wr_addr),
    .wr_data_out   (wr_data),
    .wr_last_out   (wr_last),
    .frame_done_out(frame_done),
    .front_buf_out (front_buf),
    .col_err_out   (col_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tready", 32'(tready), 32'd1);
    chk("rst_valid", 32'(wr_valid), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    chk("rst_last", 32'(wr_last), 32'd0);
    chk("rst_fdone", 32'(frame_done), 32'd0);
    chk("rst_front", 32'(front_buf), 32'd0);
    chk("rst_colerr", 32'(col_err), 32'd0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input int col, input int lh, input int ty, input int sd, input bit lst);
    int n;
    tdata  = {COL_W'(col), LH_W'(lh), TYPE_W'(ty), sd[0]};
    tlast  = lst;
    tvalid = 1'b1;
    n = 0;
    while (!tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("beat_tready", 32'(tready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  // c_rows/w_rows: hand-computed ceiling and wall row counts for this beat.
  task automatic do_column(input int col, input int lh, input int ty, input int sd, input bit lst,
                           input int base, input int c_rows, input int w_rows, input bit bp);
    int row, cyc, k;
    logic [15:0] exp_d;
    logic r;
    send_beat(col, lh, ty, sd, lst);
    chk("setup_valid", 32'(wr_valid), 32'd0);
    chk("setup_tready", 32'(tready), 32'd0);
    wr_ready = 1'b1;
    @(negedge clk);
    chk("first_valid", 32'(wr_valid), 32'd1);
    row = 0;
    cyc = 0;
    k   = 0;
    while (row < H && cyc < 100) begin
      if (row < c_rows)               exp_d = CEIL;
      else if (row < c_rows + w_rows) exp_d = {1'b1, 11'd0, sd[0], ty[2:0]};
      else                            exp_d = FLOOR;
      chk("wr_valid", 32'(wr_valid), 32'd1);
      chk("wr_addr", 32'(wr_addr), 32'(base + col + row * W));
      chk("wr_data", 32'(wr_data), 32'(exp_d));
      chk("wr_last", 32'(wr_last), 32'(lst && row == H - 1));
      chk("emit_tready", 32'(tready), 32'd0);
      r = bp ? pat[k % 4] : 1'b1;
      k++;
      wr_ready = r;
      if (r) row++;
      cyc++;
      @(negedge clk);
    end
    chk("emit_rows", 32'(row), 32'(H));
    chk("end_valid", 32'(wr_valid), 32'd0);
    chk("end_tready", 32'(tready), 32'd1);
    chk("frame_done", 32'(frame_done), 32'(lst));
    wr_ready = 1'b1;
  endtask

  task automatic drop_beat(input int col, input bit lst);
    send_beat(col, 2, 1, 0, lst);
    chk("drop_err", 32'(col_err), 32'd1);
    chk("drop_tready", 32'(tready), 32'd1);
    chk("drop_valid", 32'(wr_valid), 32'd0);
    chk("drop_fdone", 32'(frame_done), 32'(lst));
    @(negedge clk);
    chk("drop_err_clr", 32'(col_err), 32'd0);
    chk("drop_valid2", 32'(wr_valid), 32'd0);
    chk("drop_fdone_clr", 32'(frame_done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tvalid   = 1'b0;
    tdata    = '0;
    tlast    = 1'b0;
    wr_ready = 1'b0;
    rst_n    = 1'b0;
    #12;
    chk_reset_outputs();
    @(negedge clk);
    rst_n    = 1'b1;
    wr_ready = 1'b1;
    @(negedge clk);

    // Geometry cases, buffer 0
    do_column(3, 2,    5, 1, 1'b0, 0, 2, 2, 1'b0);
    do_column(4, 3,    2, 0, 1'b0, 0, 1, 3, 1'b0);
    do_column(5, 0,    1, 1, 1'b0, 0, 3, 0, 1'b0);
    do_column(6, 1023, 7, 0, 1'b0, 0, 0, 6, 1'b0);

    // Backpressure on the write port
    do_column(2, 2, 5, 1, 1'b0, 0, 2, 2, 1'b1);
    do_column(7, 4, 3, 1, 1'b0, 0, 1, 4, 1'b1);

    // Full frame into buffer 0, tlast on column 7
    for (int c = 0; c < 8; c++)
      do_column(c, 2, c % 8, c % 2, (c == 7), 0, 2, 2, 1'b0);
    chk("front_after_f1", 32'(front_buf), 32'd0);
    @(negedge clk);
    chk("fdone_pulse_once", 32'(frame_done), 32'd0);

    // Next frame lands in buffer 1
    do_column(2, 6, 1, 0, 1'b1, 48, 0, 6, 1'b0);
    chk("front_after_f2", 32'(front_buf), 32'd1);

    // Out-of-range column, then a normal one (back is buffer 0 again)
    drop_beat(8, 1'b0);
    do_column(0, 2, 4, 0, 1'b0, 0, 2, 2, 1'b0);

    // Dropped tlast beat still swaps buffers
    drop_beat(9, 1'b1);
    chk("front_after_drop", 32'(front_buf), 32'd0);
    do_column(1, 2, 6, 1, 1'b0, 48, 2, 2, 1'b0);

    // Reset while row 2 is on the bus
    send_beat(5, 2, 3, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_addr", 32'(wr_addr), 32'd69);
    chk("pre_rst_valid", 32'(wr_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_column(5, 2, 3, 0, 1'b0, 0, 2, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ray_column_rasterizer.md
Name: ray_column_rasterizer

Overview:
- Parametrised successor to the DDA-out-to-frame-buffer flattening stage.
- Consumes one AXI-stream beat per ray column from the DDA-out FIFO and emits one frame-buffer write per screen row of that column: ceiling, wall or floor.
- Adds configurable screen geometry, a valid/ready backpressured write port, optional double buffering with buffer swap on frame end, and rejection of out-of-range columns.

Parameters:
- SCREEN_W, 320, columns per frame.
- SCREEN_H, 180, rows per frame.
- COL_W, 9, column index width.
- LH_W, 10, line-height width.
- TYPE_W, 3, wall-type width.
- PIX_W, 16, pixel word width.
- NUM_BUF, 2, frame buffers (1 or 2).
- CEIL_PIX, 16'h18C3, ceiling pixel (MSB must be 0).
- FLOOR_PIX, 16'h4208, floor pixel (MSB must be 0).
- Derived: TDATA_W = COL_W+LH_W+TYPE_W+1; ADDR_W = clog2(NUM_BUF*SCREEN_W*SCREEN_H).

Ports:
- pixel_clk_in  in  1  pixel clock; sole clock.
- rst_in  in  1  asynchronous active-low reset.
- dda_tvalid_in  in  1  column beat valid.
- dda_tready_out  out  1  column beat accepted when high with valid.
- dda_tdata_in  in  TDATA_W  {column[COL_W], line_height[LH_W], wall_type[TYPE_W], side[1]}, side at bit 0.
- dda_tlast_in  in  1  last column of frame.
- wr_valid_out  out  1  write valid.
- wr_ready_in  in  1  frame buffer accepts write.
- wr_addr_out  out  ADDR_W  buf*W*H + row*W + column.
- wr_data_out  out  PIX_W  pixel.
- wr_last_out  out  1  final write of frame.
- frame_done_out  out  1  one-cycle pulse after a frame's final write.
- front_buf_out  out  1  most recently completed buffer (0 if NUM_BUF=1).
- col_err_out  out  1  one-cycle pulse when a beat is dropped.

Behaviour:
- Reset (async assert, sync release): state IDLE; dda_tready_out=1; wr_valid_out=0; wr_addr_out=0; wr_data_out=0; wr_last_out=0; frame_done_out=0; col_err_out=0; back buffer=0; front_buf_out=0.
- IDLE: tready=1. On tvalid&tready, latch all fields and tlast, then go to SETUP.
  - If column>=SCREEN_W: drop the beat. Pulse col_err_out next cycle and stay IDLE.
  - If a dropped beat carries tlast, still run the frame-end actions (swap, frame_done pulse) with no wr_last.
- SETUP (1 cycle): tready=0.
  - lh_c = min(line_height, SCREEN_H).
  - start = (SCREEN_H-lh_c)>>1 (floor); end = start+lh_c-1.
  - lh_c=0 means no wall rows.
  - row=0; go to EMIT.
- EMIT: wr_valid=1; tready=0.
  - Pixel is CEIL_PIX for row<start, FLOOR_PIX for row>end, otherwise {1'b1, zero pad, side, wall_type}.
  - Address and data are registered. They hold stable while valid&!ready (AXI rules; valid never drops without a handshake).
  - On handshake: row++ and next address += SCREEN_W (no multiplier in the row loop).
  - Handshake with row=SCREEN_H-1: wr_valid=0 next cycle; go to IDLE.
- Latency: beat accepted at cycle 0 gives first wr_valid at cycle 2. With ready held high, one column takes SCREEN_H+2 cycles.
- wr_last_out=1 only on the row SCREEN_H-1 write of a tlast column.
- Frame end (that write handshakes):
  - Next cycle: frame_done_out pulses, front_buf_out <= back buffer, back buffer toggles (NUM_BUF=2 only).
  - Writes always target the back buffer; the buffer base is captured in SETUP.
- Reset mid-EMIT: write abandoned, wr_valid drops immediately, back buffer returns to 0.
- wr_ready asserted while wr_valid is low is ignored.

Test Plan:
- W=8, H=6, NUM_BUF=1, beat col=3, lh=2, type=5, side=1, ready=1: six writes at addr 3,11,19,27,35,43; data CEIL,CEIL,16'h800D,16'h800D,FLOOR,FLOOR; first valid 2 cycles after accept.
- Same geometry: lh=3 gives wall rows 1-3. lh=0 gives no wall rows. lh=1023 clamps to all 6 rows wall.
- Backpressure: ready toggles 1,0,0,1 pseudo-randomly. addr/data hold while stalled, no write lost or duplicated, tready=0 throughout EMIT.
- NUM_BUF=2, W=8, H=6: frame of 8 columns, last with tlast. wr_last only on addr 47. frame_done pulses once, front_buf=0. Next frame writes base 48, then front_buf=1.
- Beat col=8 with W=8: no writes, col_err pulse, tready stays 1. Next valid beat col=0 emits normally.
- Assert rst_in low during row 2 of EMIT: wr_valid=0 asynchronously, all outputs at reset values. Column restarts correctly after release.
